sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
Clocked model of the off-chip 256Kx16 asynchronous SRAM. It sits on the far side of the SRAM pin bus, opposite the memory-stage SRAM controller, and answers its read and write cycles. It is used in system simulation and as an on-FPGA stand-in, with configurable read latency and write-pulse checking. It also exposes access counters and protocol-error pulses so the bench can verify the controller's timing.

Parameters:
ADDR_W, 10, number of low SRAM_ADDR bits that index storage (depth 2^ADDR_W words)
READ_LAT, 1, cycles from a sampled read request to valid DQ drive (1..15)
WR_MIN, 2, minimum number of consecutive cycles WE_N must be sampled low for a write to commit (1..15)

Ports:
clk  in  1  system clock; all sampling on rising edge
rst  in  1  synchronous, active-high reset
SRAM_ADDR  in  18  word address; only [ADDR_W-1:0] used, upper bits ignored (wrap)
SRAM_CE_N  in  1  chip enable, active low
SRAM_OE_N  in  1  output enable, active low
SRAM_WE_N  in  1  write enable, active low
SRAM_UB_N  in  1  upper byte lane enable, active low
SRAM_LB_N  in  1  lower byte lane enable, active low
SRAM_DQ  inout  16  bidirectional data; driven only in RD_DRIVE, per byte lane
rd_count  out  16  completed read accesses (entries into RD_DRIVE), wraps at 0xFFFF
wr_count  out  16  committed writes, wraps
wr_err  out  1  one-cycle pulse: write pulse shorter than WR_MIN, discarded
bus_err  out  1  one-cycle pulse: OE_N and WE_N sampled low together with CE_N low

Behaviour:
- Reset (rst=1 at an edge) clears these: state to IDLE, SRAM_DQ to Z on both lanes from the next cycle, rd_count and wr_count to 0, wr_err and bus_err to 0, latency counter to 0.
- Reset does not clear storage contents. An in-flight write is aborted without commit.
- States: IDLE, RD_WAIT, RD_DRIVE, WR_LOW.
- IDLE, CE_N=1: stay in IDLE, DQ Z.
- IDLE, CE_N=0 and WE_N=0: latch address, go to WR_LOW, low-count = 1. Write has priority over OE_N; bus_err pulses if OE_N=0 as well.
- IDLE, CE_N=0, WE_N=1, OE_N=0: latch address, load counter with READ_LAT-1. If READ_LAT=1, go directly to RD_DRIVE; otherwise go to RD_WAIT.
- RD_WAIT: DQ Z.
  - Counter decrements each cycle; at 0, go to RD_DRIVE.
  - If OE_N=1, CE_N=1 or WE_N=0 is sampled, abort the read: go to IDLE, or to WR_LOW if WE_N=0.
  - If the address changes, re-latch it and reload the counter.
- RD_DRIVE:
  - DQ[15:8] = mem[addr][15:8] when UB_N=0, else Z. DQ[7:0] = mem[addr][7:0] when LB_N=0, else Z. Lane enables are the live sampled values.
  - rd_count increments once on entry.
  - Data is valid READ_LAT edges after the edge that sampled the request.
  - Address change while OE_N=0: re-latch, go to RD_WAIT (or stay in RD_DRIVE with the new data when READ_LAT=1); DQ Z during the wait. rd_count increments on each re-entry.
  - OE_N=1 or CE_N=1: DQ Z from the next cycle, go to IDLE.
  - WE_N=0: DQ Z next cycle, go to WR_LOW.
- DQ is never driven in any cycle where WE_N was sampled low.
- WR_LOW:
  - Each cycle WE_N=0 is sampled, capture DQ, UB_N and LB_N into holding registers and increment the saturating low-count.
  - When WE_N=1 is sampled and low-count >= WR_MIN: commit the held data to the held lanes of mem[latched addr], increment wr_count, go to IDLE. Commit is visible to a read request sampled on the same edge.
  - When WE_N=1 is sampled and low-count < WR_MIN: no commit, wr_err pulses, go to IDLE.
  - CE_N=1 while WE_N=0: treat as WE rising edge (same commit/discard rule).
  - Address change during WR_LOW is ignored (first latched address wins).
- bus_err pulses on every edge where CE_N=0, OE_N=0 and WE_N=0 are sampled together.
- Counters: 16-bit modulo.

Test Plan:
- Write 0xBEEF to addr 0x00005: WE_N low 2 cycles, UB/LB low, release. Then read with READ_LAT=2. Required: wr_count=1; DQ Z for 1 cycle then 0xBEEF on the 2nd edge after the request; rd_count=1.
- Byte-lane write: pre-load 0x1234 at addr 7, write 0xABCD with UB_N=1, LB_N=0. Required: readback 0x12CD. A read with LB_N=1 shows DQ[7:0]=Z and DQ[15:8]=0x12.
- Short write, WR_MIN=2: WE_N low 1 cycle with 0x5555 to addr 3. Required: wr_err pulses once, wr_count unchanged, addr 3 keeps its old value.
- Contention: OE_N and WE_N low together with 0x0F0F on DQ. Required: bus_err pulses every such cycle, responder never drives DQ, write of 0x0F0F commits.
- Address wrap, ADDR_W=10: write 0x7777 to addr 0x00401. Required: read of addr 0x00001 returns 0x7777.
- Reset mid-write: assert rst in the 2nd WE_N-low cycle. Required: no commit, counters 0, DQ Z. Also hold OE_N low and step the address 2→3 in RD_DRIVE: DQ goes Z, then mem[3] after READ_LAT cycles, rd_count +1.

Source files
------------

// File: rtl/sram_responder.sv
// sram_responder: clocked model of a 256Kx16 asynchronous SRAM. It answers
// the controller's read and write cycles on the SRAM pin bus, with
// programmable read latency and a minimum write-pulse length check.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   SRAM_ADDR         word address; only [ADDR_W-1:0] indexes storage
//   SRAM_CE_N/OE_N/WE_N/UB_N/LB_N  active-low controls and byte-lane enables
//   SRAM_DQ           bidirectional data, driven only while serving a read
//   rd_count          reads delivered (entries into the drive state)
//   wr_count          writes committed
//   wr_err            one-cycle pulse: write pulse too short, data discarded
//   bus_err           one-cycle pulse: OE_N and WE_N low together under CE_N
//
// Read latency counts the edge that samples the request as edge 1: with
// READ_LAT=N the data appears right after the N-th edge.
module sram_responder #(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 1,
    parameter int WR_MIN   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] SRAM_ADDR,
    input  logic        SRAM_CE_N,
    input  logic        SRAM_OE_N,
    input  logic        SRAM_WE_N,
    input  logic        SRAM_UB_N,
    input  logic        SRAM_LB_N,
    inout  wire  [15:0] SRAM_DQ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic        wr_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR_LOW} state_t;

    localparam int         DEPTH      = 1 << ADDR_W;
    localparam logic [3:0] LAT_RELOAD = 4'(READ_LAT - 1);
    localparam logic [3:0] WR_MIN_C   = 4'(WR_MIN);

    logic [15:0] mem [0:DEPTH-1];

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          low_q, low_d;
    logic [15:0]         hold_data_q, hold_data_d;
    logic                hold_ub_q, hold_ub_d;
    logic                hold_lb_q, hold_lb_d;
    logic [15:0]         rd_count_q, rd_count_d;
    logic [15:0]         wr_count_q, wr_count_d;
    logic                wr_err_q, wr_err_d;
    logic                bus_err_q, bus_err_d;
    logic [1:0]          dq_oe_q, dq_oe_d;     // {upper, lower} lane drive
    logic [15:0]         rd_data_q;

    logic                ce, oe, we, ub, lb;
    logic                wr_req, rd_req;
    logic                go_wr, go_drive, commit, rd_load;
    logic [ADDR_W-1:0]   addr_in, rd_addr;
    logic                unused_addr;

    assign ce      = ~SRAM_CE_N;
    assign oe      = ~SRAM_OE_N;
    assign we      = ~SRAM_WE_N;
    assign ub      = ~SRAM_UB_N;
    assign lb      = ~SRAM_LB_N;
    assign addr_in = SRAM_ADDR[ADDR_W-1:0];
    // Upper address bits alias onto the implemented depth.
    assign unused_addr = ^SRAM_ADDR[17:ADDR_W];

    // Write wins over OE whenever the chip is selected.
    assign wr_req = ce & we;
    assign rd_req = ce & oe & ~we;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        low_d       = low_q;
        hold_data_d = hold_data_q;
        hold_ub_d   = hold_ub_q;
        hold_lb_d   = hold_lb_q;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        wr_err_d    = 1'b0;
        bus_err_d   = ce & oe & we;
        dq_oe_d     = 2'b00;
        go_wr       = 1'b0;
        go_drive    = 1'b0;
        commit      = 1'b0;
        rd_load     = 1'b0;
        rd_addr     = addr_q;

        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    go_wr = 1'b1;
                end else if (rd_req) begin
                    addr_d = addr_in;
                    if (READ_LAT == 1) begin
                        go_drive = 1'b1;
                        rd_addr  = addr_in;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = LAT_RELOAD;
                    end
                end
            end
            RD_WAIT: begin
                if (wr_req) begin
                    go_wr = 1'b1;
                end else if (!rd_req) begin
                    state_d = IDLE;
                end else if (addr_in != addr_q) begin
                    addr_d = addr_in;
                    cnt_d  = LAT_RELOAD;
                end else if (cnt_q <= 4'd1) begin
                    go_drive = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_DRIVE: begin
                if (wr_req) begin
                    go_wr = 1'b1;
                end else if (!rd_req) begin
                    state_d = IDLE;
                end else if (addr_in != addr_q) begin
                    addr_d = addr_in;
                    if (READ_LAT == 1) begin
                        go_drive = 1'b1;
                        rd_addr  = addr_in;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = LAT_RELOAD;
                    end
                end else begin
                    // Lane enables follow the live UB_N/LB_N while serving.
                    dq_oe_d = {ub, lb};
                end
            end
            WR_LOW: begin
                if (wr_req) begin
                    if (low_q != 4'hF) begin
                        low_d = low_q + 4'd1;
                    end
                    hold_data_d = SRAM_DQ;
                    hold_ub_d   = ub;
                    hold_lb_d   = lb;
                end else begin
                    // WE_N rising or CE_N rising both end the pulse.
                    state_d = IDLE;
                    if (low_q >= WR_MIN_C) begin
                        commit     = ~rst;
                        wr_count_d = wr_count_q + 16'd1;
                    end else begin
                        wr_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (go_wr) begin
            state_d     = WR_LOW;
            addr_d      = addr_in;
            low_d       = 4'd1;
            hold_data_d = SRAM_DQ;
            hold_ub_d   = ub;
            hold_lb_d   = lb;
        end

        if (go_drive) begin
            state_d    = RD_DRIVE;
            rd_load    = ~rst;
            rd_count_d = rd_count_q + 16'd1;
            dq_oe_d    = {ub, lb};
            cnt_d      = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            low_q      <= 4'd0;
            rd_count_q <= 16'd0;
            wr_count_q <= 16'd0;
            wr_err_q   <= 1'b0;
            bus_err_q  <= 1'b0;
            dq_oe_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            low_q      <= low_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            wr_err_q   <= wr_err_d;
            bus_err_q  <= bus_err_d;
            dq_oe_q    <= dq_oe_d;
        end
        // Datapath registers carry no reset; they are qualified by state.
        addr_q      <= addr_d;
        hold_data_q <= hold_data_d;
        hold_ub_q   <= hold_ub_d;
        hold_lb_q   <= hold_lb_d;
    end

    // Storage survives reset; byte-lane writes and a registered read port.
    always_ff @(posedge clk) begin
        if (commit) begin
            if (hold_ub_q) begin
                mem[addr_q][15:8] <= hold_data_q[15:8];
            end
            if (hold_lb_q) begin
                mem[addr_q][7:0] <= hold_data_q[7:0];
            end
        end
        if (rd_load) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign SRAM_DQ[15:8] = dq_oe_q[1] ? rd_data_q[15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = dq_oe_q[0] ? rd_data_q[7:0]  : 8'hzz;

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
    assign wr_err   = wr_err_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder with READ_LAT=2, WR_MIN=2, ADDR_W=10.
// The DQ bus carries a pull-up, so an undriven lane reads as all ones;
// test data therefore avoids 0xFF bytes.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] sram_addr = 18'd0;
    logic        ce_n = 1'b1;
    logic        oe_n = 1'b1;
    logic        we_n = 1'b1;
    logic        ub_n = 1'b0;
    logic        lb_n = 1'b0;
    wire  [15:0] sram_dq;
    logic [15:0] tb_dq = 16'h0000;
    logic        tb_dq_en = 1'b0;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic        wr_err;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    assign sram_dq = tb_dq_en ? tb_dq : 16'hzzzz;
    pullup (sram_dq);

    always #5 clk = ~clk;

    sram_responder #(
        .ADDR_W  (10),
        .READ_LAT(2),
        .WR_MIN  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .SRAM_ADDR(sram_addr),
        .SRAM_CE_N(ce_n),
        .SRAM_OE_N(oe_n),
        .SRAM_WE_N(we_n),
        .SRAM_UB_N(ub_n),
        .SRAM_LB_N(lb_n),
        .SRAM_DQ  (sram_dq),
        .rd_count (rd_count),
        .wr_count (wr_count),
        .wr_err   (wr_err),
        .bus_err  (bus_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
        ub_n = 1'b0; lb_n = 1'b0; tb_dq_en = 1'b0;
    endtask

    // Drives a write pulse of nlow sampled-low cycles, then the release edge.
    task automatic do_write(input logic [17:0] a, input logic [15:0] d,
                            input logic ubn, input logic lbn, input int nlow);
        sram_addr = a; tb_dq = d; tb_dq_en = 1'b1;
        ub_n = ubn; lb_n = lbn; ce_n = 1'b0; we_n = 1'b0;
        repeat (nlow) step();
        bus_idle();
        step();
        $display("write addr=%05h data=%04h ub_n=%0b lb_n=%0b low=%0d", a, d, ubn, lbn, nlow);
    endtask

    task automatic rd_begin(input logic [17:0] a);
        sram_addr = a; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    endtask

    task automatic test_reset();
        step(); step();
        total++; if (rd_count !== 16'd0) begin bad++; $display("FAIL reset_rd_count got=%h want=0000", rd_count); end
        total++; if (wr_count !== 16'd0) begin bad++; $display("FAIL reset_wr_count got=%h want=0000", wr_count); end
        total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL reset_wr_err got=%b want=0", wr_err); end
        total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL reset_bus_err got=%b want=0", bus_err); end
        total++; if (sram_dq !== 16'hFFFF) begin bad++; $display("FAIL reset_dq_z got=%h want=FFFF", sram_dq); end
        rst = 1'b0;
        step();
        $display("reset released");
    endtask

    task automatic test_write_read();
        do_write(18'h00005, 16'hBEEF, 1'b0, 1'b0, 2);
        total++; if (wr_count !== 16'd1) begin bad++; $display("FAIL wr_basic_count got=%h want=0001", wr_count); end
        total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL wr_basic_err got=%b want=0", wr_err); end
        rd_begin(18'h00005);
        step();
        total++; if (sram_dq !== 16'hFFFF) begin bad++; $display("FAIL rd_basic_wait_z got=%h want=FFFF", sram_dq); end
        step();
        total++; if (sram_dq !== 16'hBEEF) begin bad++; $display("FAIL rd_basic_data got=%h want=BEEF", sram_dq); end
        total++; if (rd_count !== 16'd1) begin bad++; $display("FAIL rd_basic_count got=%h want=0001", rd_count); end
        bus_idle();
        step();
        total++; if (sram_dq !== 16'hFFFF) begin bad++; $display("FAIL rd_basic_release_z got=%h want=FFFF", sram_dq); end
        $display("read addr=00005 data=%04h", 16'hBEEF);
    endtask

    task automatic test_byte_lane();
        do_write(18'h00007, 16'h1234, 1'b0, 1'b0, 2);
        do_write(18'h00007, 16'hABCD, 1'b1, 1'b0, 2);
        total++; if (wr_count !== 16'd3) begin bad++; $display("FAIL lane_wr_count got=%h want=0003", wr_count); end
        rd_begin(18'h00007);
        step(); step();
        total++; if (sram_dq !== 16'h12CD) begin bad++; $display("FAIL lane_merge got=%h want=12CD", sram_dq); end
        lb_n = 1'b1;
        step();
        total++; if (sram_dq !== 16'h12FF) begin bad++; $display("FAIL lane_lb_off got=%h want=12FF", sram_dq); end
        total++; if (rd_count !== 16'd2) begin bad++; $display("FAIL lane_rd_count got=%h want=0002", rd_count); end
        bus_idle();
        step();
        $display("read addr=00007 byte lanes checked");
    endtask

    task automatic test_short_write();
        do_write(18'h00003, 16'h0303, 1'b0, 1'b0, 2);
        do_write(18'h00003, 16'h5555, 1'b0, 1'b0, 1);
        total++; if (wr_err !== 1'b1) begin bad++; $display("FAIL short_err_pulse got=%b want=1", wr_err); end
        total++; if (wr_count !== 16'd4) begin bad++; $display("FAIL short_wr_count got=%h want=0004", wr_count); end
        step();
        total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL short_err_single got=%b want=0", wr_err); end
        rd_begin(18'h00003);
        step(); step();
        total++; if (sram_dq !== 16'h0303) begin bad++; $display("FAIL short_keep_old got=%h want=0303", sram_dq); end
        bus_idle();
        step();
        $display("short write to addr=00003 discarded");
    endtask

    task automatic test_contention();
        sram_addr = 18'h00009; tb_dq = 16'h0F0F; tb_dq_en = 1'b1;
        ub_n = 1'b0; lb_n = 1'b0; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            total++; if (bus_err !== 1'b1) begin bad++; $display("FAIL cont_bus_err cycle=%0d got=%b want=1", c, bus_err); end
            tb_dq_en = 1'b0;
            #1;
            total++; if (sram_dq !== 16'hFFFF) begin bad++; $display("FAIL cont_no_drive cycle=%0d got=%h want=FFFF", c, sram_dq); end
            tb_dq_en = 1'b1;
        end
        bus_idle();
        step();
        total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL cont_bus_err_clear got=%b want=0", bus_err); end
        total++; if (wr_count !== 16'd5) begin bad++; $display("FAIL cont_wr_count got=%h want=0005", wr_count); end
        rd_begin(18'h00009);
        step(); step();
        total++; if (sram_dq !== 16'h0F0F) begin bad++; $display("FAIL cont_commit got=%h want=0F0F", sram_dq); end
        bus_idle();
        step();
        $display("contention write addr=00009 data=0F0F");
    endtask

    task automatic test_wrap();
        do_write(18'h00401, 16'h7777, 1'b0, 1'b0, 2);
        rd_begin(18'h00001);
        step(); step();
        total++; if (sram_dq !== 16'h7777) begin bad++; $display("FAIL wrap_data got=%h want=7777", sram_dq); end
        total++; if (rd_count !== 16'd5) begin bad++; $display("FAIL wrap_rd_count got=%h want=0005", rd_count); end
        bus_idle();
        step();
        $display("read addr=00001 via alias 00401");
    endtask

    task automatic test_reset_mid_write();
        do_write(18'h0000A, 16'h2222, 1'b0, 1'b0, 2);
        sram_addr = 18'h0000A; tb_dq = 16'h1111; tb_dq_en = 1'b1;
        ce_n = 1'b0; we_n = 1'b0;
        step();
        rst = 1'b1;
        step();
        total++; if (rd_count !== 16'd0) begin bad++; $display("FAIL rstw_rd_count got=%h want=0000", rd_count); end
        total++; if (wr_count !== 16'd0) begin bad++; $display("FAIL rstw_wr_count got=%h want=0000", wr_count); end
        rst = 1'b0;
        bus_idle();
        step();
        total++; if (wr_count !== 16'd0) begin bad++; $display("FAIL rstw_no_commit_count got=%h want=0000", wr_count); end
        total++; if (sram_dq !== 16'hFFFF) begin bad++; $display("FAIL rstw_dq_z got=%h want=FFFF", sram_dq); end
        rd_begin(18'h0000A);
        step(); step();
        total++; if (sram_dq !== 16'h2222) begin bad++; $display("FAIL rstw_mem_kept got=%h want=2222", sram_dq); end
        bus_idle();
        step();
        $display("reset during write to addr=0000A aborted");
    endtask

    task automatic test_addr_step();
        do_write(18'h00002, 16'h2C2C, 1'b0, 1'b0, 2);
        rd_begin(18'h00002);
        step(); step();
        total++; if (sram_dq !== 16'h2C2C) begin bad++; $display("FAIL step_first got=%h want=2C2C", sram_dq); end
        total++; if (rd_count !== 16'd2) begin bad++; $display("FAIL step_count_first got=%h want=0002", rd_count); end
        sram_addr = 18'h00003;
        step();
        total++; if (sram_dq !== 16'hFFFF) begin bad++; $display("FAIL step_wait_z got=%h want=FFFF", sram_dq); end
        total++; if (rd_count !== 16'd2) begin bad++; $display("FAIL step_count_wait got=%h want=0002", rd_count); end
        step();
        total++; if (sram_dq !== 16'h0303) begin bad++; $display("FAIL step_second got=%h want=0303", sram_dq); end
        total++; if (rd_count !== 16'd3) begin bad++; $display("FAIL step_count_second got=%h want=0003", rd_count); end
        bus_idle();
        step();
        $display("read addr step 00002->00003");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lane();
        test_short_write();
        test_contention();
        test_wrap();
        test_reset_mid_write();
        test_addr_step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
